fetch_stage: RTL and testbench

//  Instruction-fetch stage. Owns the PC, drives the byte address into the combinational

---
 rtl/fetch_stage_pkg.sv | 19 +
 rtl/fetch_stage_if.sv | 30 +++
 rtl/fetch_slot.sv | 60 ++++++
 rtl/fetch_stage.sv | 123 ++++++++++++
 tb/tb_fetch_stage.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage definitions: word width, NOP encoding, PC step and FSM state encoding.
package fetch_stage_pkg;

  localparam int unsigned     XLEN    = 32;
  localparam logic [XLEN-1:0] INS_NOP = 32'h0000_0013;  // addi x0, x0, 0
  localparam logic [XLEN-1:0] PC_STEP = 32'd4;

  typedef enum logic [1:0] {
    FsIdle = 2'd0,
    FsRun  = 2'd1,
    FsHalt = 2'd2
  } fetch_state_e;

  // Any address not a multiple of the word size cannot be fetched.
  function automatic logic pc_misaligned(input logic [XLEN-1:0] pc);
    return (pc & (PC_STEP - 32'd1)) != '0;
  endfunction

endpackage

// File: rtl/fetch_stage_if.sv
// Fetch-stage bus: combinational instruction-memory port plus the valid/ready slot to decode.
interface fetch_stage_if;
  import fetch_stage_pkg::*;

  logic [XLEN-1:0] imem_addr;
  logic [XLEN-1:0] imem_ins;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_ins;
  logic [XLEN-1:0] out_pc;

  modport master (
    output imem_addr,
    input  imem_ins,
    output out_valid,
    input  out_ready,
    output out_ins,
    output out_pc
  );

  modport slave (
    input  imem_addr,
    output imem_ins,
    input  out_valid,
    output out_ready,
    input  out_ins,
    input  out_pc
  );

endinterface

// File: rtl/fetch_slot.sv
// Single-entry valid/ready holding register between fetch and decode (load, hold, flush).
module fetch_slot
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] NOP_INS = INS_NOP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            load,
  input  logic            flush,
  input  logic [XLEN-1:0] in_ins,
  input  logic [XLEN-1:0] in_pc,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] out_ins,
  output logic [XLEN-1:0] out_pc,
  output logic            free
);

  logic            valid_q, valid_d;
  logic [XLEN-1:0] ins_q, ins_d;
  logic [XLEN-1:0] pc_q, pc_d;

  assign free = !valid_q || out_ready;

  always_comb begin
    valid_d = valid_q;
    ins_d   = ins_q;
    pc_d    = pc_q;
    if (flush) begin
      valid_d = 1'b0;
      ins_d   = NOP_INS;
    end else if (load) begin
      valid_d = 1'b1;
      ins_d   = in_ins;
      pc_d    = in_pc;
    end else if (valid_q && out_ready) begin
      // Drained without refill: present a NOP while empty.
      valid_d = 1'b0;
      ins_d   = NOP_INS;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ins_q   <= NOP_INS;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ins_q   <= ins_d;
      pc_q    <= pc_d;
    end
  end

  assign out_valid = valid_q;
  assign out_ins   = ins_q;
  assign out_pc    = pc_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC, IDLE/RUN/HALT FSM, redirect and sticky fault handling.
// Define FETCH_RANGE_CHECK_EN to also fault on fetches beyond the instruction memory.
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned     IMEM_BYTES = 80,
  parameter logic [XLEN-1:0] NOP_INS    = INS_NOP
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fetch_en,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_pc,
  fetch_stage_if.master   bus,
  output logic            fault,
  output logic [XLEN-1:0] fault_pc
);

  localparam logic [XLEN-1:0] PC_LIMIT = XLEN'(IMEM_BYTES - 4);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            fault_q, fault_d;
  logic [XLEN-1:0] fault_pc_q, fault_pc_d;

  logic slot_load;
  logic slot_flush;
  logic slot_free;
  logic pc_over;
  logic pc_bad;

  assign pc_over = pc_q > PC_LIMIT;

`ifdef FETCH_RANGE_CHECK_EN
  assign pc_bad = pc_misaligned(pc_q) || pc_over;
`else
  logic unused_pc_over;
  assign unused_pc_over = pc_over;
  assign pc_bad         = pc_misaligned(pc_q);
`endif

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    fault_d    = fault_q;
    fault_pc_d = fault_pc_q;
    slot_load  = 1'b0;
    slot_flush = 1'b0;

    if (redirect_valid) begin
      // Target is validated next cycle, when it becomes the PC about to be fetched.
      pc_d       = redirect_pc;
      slot_flush = 1'b1;
      state_d    = fetch_en ? FsRun : FsIdle;
    end else begin
      unique case (state_q)
        FsIdle: begin
          if (pc_bad) begin
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
            state_d    = FsHalt;
          end else if (fetch_en) begin
            state_d = FsRun;
          end
        end
        FsRun: begin
          if (pc_bad) begin
            fault_d    = 1'b1;
            fault_pc_d = pc_q;
            state_d    = FsHalt;
          end else if (!fetch_en) begin
            state_d = FsIdle;
          end else if (slot_free) begin
            slot_load = 1'b1;
            pc_d      = pc_q + PC_STEP;
          end
        end
        FsHalt: begin
          state_d = FsHalt;
        end
        default: begin
          state_d = FsIdle;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= FsIdle;
      pc_q       <= RESET_PC;
      fault_q    <= 1'b0;
      fault_pc_q <= '0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fault_q    <= fault_d;
      fault_pc_q <= fault_pc_d;
    end
  end

  fetch_slot #(
    .NOP_INS (NOP_INS)
  ) u_slot (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (slot_load),
    .flush     (slot_flush),
    .in_ins    (bus.imem_ins),
    .in_pc     (pc_q),
    .out_ready (bus.out_ready),
    .out_valid (bus.out_valid),
    .out_ins   (bus.out_ins),
    .out_pc    (bus.out_pc),
    .free      (slot_free)
  );

  assign bus.imem_addr = pc_q;
  assign fault         = fault_q;
  assign fault_pc      = fault_pc_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: expected (pc, ins) pairs are queued as stimulus is set up
// and retired on each decode handoff; cycle-level behaviour is checked directly.
module tb_fetch_stage;
  import fetch_stage_pkg::*;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic        fetch_en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        fault;
  logic [31:0] fault_pc;

  int unsigned n_checks;
  int unsigned n_errors;
  exp_t        sb_q[$];

  fetch_stage_if bus();

  fetch_stage dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .fetch_en       (fetch_en),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .bus            (bus),
    .fault          (fault),
    .fault_pc       (fault_pc)
  );

  function automatic logic [31:0] ins_at(input logic [31:0] a);
    logic [31:0] r;
    case (a)
      32'd0:   r = 32'h0050_0093;
      32'd4:   r = 32'h0090_0113;
      32'd8:   r = 32'h0020_80B3;
      32'd12:  r = 32'h0020_A4A3;
      default: r = (a << 20) | 32'h0000_0013;  // addi x0, x0, <addr>
    endcase
    return r;
  endfunction

  assign bus.imem_ins = ins_at(bus.imem_addr);

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  task automatic push_exp(input logic [31:0] pc);
    exp_t e;
    e.pc  = pc;
    e.ins = ins_at(pc);
    sb_q.push_back(e);
  endtask

  // Retire one expected entry per decode handoff.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      if (sb_q.size() == 0) begin
        check_eq("sb_unexpected_pc", bus.out_pc, 32'hFFFF_FFFF);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check_eq("sb_pc", bus.out_pc, e.pc);
        check_eq("sb_ins", bus.out_ins, e.ins);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n          = 1'b0;
    fetch_en       = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    bus.out_ready  = 1'b1;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  task automatic end_test(input string tag);
    fetch_en = 1'b0;
    step();
    step();
    check_eq({tag, "_sb_left"}, sb_q.size(), 32'd0);
    check_eq({tag, "_drained"}, {31'd0, bus.out_valid}, 32'd0);
    sb_q.delete();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    n_checks = 0;
    n_errors = 0;

    // 1: reset values, then back-to-back fetch at one word per cycle.
    do_reset();
    check_eq("rst_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("rst_ins", bus.out_ins, 32'h0000_0013);
    check_eq("rst_pc", bus.out_pc, 32'd0);
    check_eq("rst_fault", {31'd0, fault}, 32'd0);
    check_eq("rst_fault_pc", fault_pc, 32'd0);
    check_eq("rst_addr", bus.imem_addr, 32'd0);
    for (int i = 0; i < 4; i++) push_exp(32'(i * 4));
    fetch_en = 1'b1;
    step();
    check_eq("t1_idle_valid", {31'd0, bus.out_valid}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      step();
      check_eq("t1_valid", {31'd0, bus.out_valid}, 32'd1);
      check_eq("t1_pc", bus.out_pc, 32'(i * 4));
      check_eq("t1_ins", bus.out_ins, ins_at(32'(i * 4)));
    end
    end_test("t1");

    // 2: decode back-pressure holds slot and PC.
    do_reset();
    push_exp(32'd0);
    push_exp(32'd4);
    fetch_en = 1'b1;
    step();
    step();
    bus.out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check_eq("t2_hold_valid", {31'd0, bus.out_valid}, 32'd1);
      check_eq("t2_hold_pc", bus.out_pc, 32'd0);
      check_eq("t2_hold_ins", bus.out_ins, 32'h0050_0093);
      check_eq("t2_hold_addr", bus.imem_addr, 32'd4);
    end
    bus.out_ready = 1'b1;
    step();
    check_eq("t2_resume_pc", bus.out_pc, 32'd4);
    check_eq("t2_resume_ins", bus.out_ins, 32'h0090_0113);
    end_test("t2");

    // 3: redirect while the slot is full costs one bubble.
    do_reset();
    push_exp(32'd0);
    push_exp(32'd8);
    fetch_en = 1'b1;
    step();
    step();
    check_eq("t3_first_pc", bus.out_pc, 32'd0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd8;
    step();
    redirect_valid = 1'b0;
    check_eq("t3_bubble", {31'd0, bus.out_valid}, 32'd0);
    check_eq("t3_addr", bus.imem_addr, 32'd8);
    step();
    check_eq("t3_valid", {31'd0, bus.out_valid}, 32'd1);
    check_eq("t3_pc", bus.out_pc, 32'd8);
    check_eq("t3_ins", bus.out_ins, 32'h0020_80B3);
    end_test("t3");

    // 4: misaligned redirect faults and halts; a good redirect resumes, fault stays.
    do_reset();
    push_exp(32'd0);
    fetch_en       = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc    = 32'd6;
    step();
    redirect_valid = 1'b0;
    check_eq("t4_addr6", bus.imem_addr, 32'd6);
    check_eq("t4_no_fault_yet", {31'd0, fault}, 32'd0);
    step();
    check_eq("t4_fault", {31'd0, fault}, 32'd1);
    check_eq("t4_fault_pc", fault_pc, 32'd6);
    check_eq("t4_valid", {31'd0, bus.out_valid}, 32'd0);
    step();
    check_eq("t4_halt_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("t4_halt_addr", bus.imem_addr, 32'd6);
    redirect_valid = 1'b1;
    redirect_pc    = 32'd0;
    step();
    redirect_valid = 1'b0;
    check_eq("t4_redir_addr", bus.imem_addr, 32'd0);
    step();
    check_eq("t4_resume_pc", bus.out_pc, 32'd0);
    check_eq("t4_resume_ins", bus.out_ins, 32'h0050_0093);
    check_eq("t4_sticky", {31'd0, fault}, 32'd1);
    check_eq("t4_sticky_pc", fault_pc, 32'd6);
    end_test("t4");

    // 5: sequential run to the end of instruction memory.
    do_reset();
    for (int i = 0; i < 20; i++) push_exp(32'(i * 4));
`ifndef FETCH_RANGE_CHECK_EN
    push_exp(32'd80);
`endif
    fetch_en = 1'b1;
    step();
    repeat (20) step();
    check_eq("t5_last_pc", bus.out_pc, 32'd76);
    step();
`ifdef FETCH_RANGE_CHECK_EN
    check_eq("t5_range_fault", {31'd0, fault}, 32'd1);
    check_eq("t5_range_fault_pc", fault_pc, 32'd80);
    check_eq("t5_range_valid", {31'd0, bus.out_valid}, 32'd0);
`else
    check_eq("t5_no_fault", {31'd0, fault}, 32'd0);
    check_eq("t5_pc80", bus.out_pc, 32'd80);
    check_eq("t5_ins80", bus.out_ins, ins_at(32'd80));
`endif
    end_test("t5");

    // 6: asynchronous reset mid-stall, then restart from the reset PC.
    do_reset();
    fetch_en = 1'b1;
    step();
    step();
    bus.out_ready = 1'b0;
    step();
    check_eq("t6_stall_valid", {31'd0, bus.out_valid}, 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_valid", {31'd0, bus.out_valid}, 32'd0);
    check_eq("t6_async_ins", bus.out_ins, 32'h0000_0013);
    check_eq("t6_async_pc", bus.out_pc, 32'd0);
    check_eq("t6_async_addr", bus.imem_addr, 32'd0);
    bus.out_ready = 1'b1;
    #3;
    rst_n = 1'b1;
    push_exp(32'd0);
    step();
    step();
    check_eq("t6_restart_valid", {31'd0, bus.out_valid}, 32'd1);
    check_eq("t6_restart_pc", bus.out_pc, 32'd0);
    check_eq("t6_restart_ins", bus.out_ins, 32'h0050_0093);
    end_test("t6");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
